// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs and the decode bundle.
package y86_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned NREGS  = 15;

    typedef logic [3:0]        reg_id_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_id_t RSP_ID = 4'd4;
    localparam reg_id_t RNONE  = 4'hF;

    localparam logic [3:0] ICodeHalt   = 4'h0;
    localparam logic [3:0] ICodeNop    = 4'h1;
    localparam logic [3:0] ICodeCmov   = 4'h2;
    localparam logic [3:0] ICodeIrmovq = 4'h3;
    localparam logic [3:0] ICodeRmmovq = 4'h4;
    localparam logic [3:0] ICodeMrmovq = 4'h5;
    localparam logic [3:0] ICodeOpq    = 4'h6;
    localparam logic [3:0] ICodeJxx    = 4'h7;
    localparam logic [3:0] ICodeCall   = 4'h8;
    localparam logic [3:0] ICodeRet    = 4'h9;
    localparam logic [3:0] ICodePushq  = 4'hA;
    localparam logic [3:0] ICodePopq   = 4'hB;

    typedef struct packed {
        logic       valid;
        logic [3:0] icode;
        logic [3:0] ifun;
        word_t      valc;
        word_t      valp;
        reg_id_t    srca;
        reg_id_t    srcb;
        reg_id_t    dste;
        reg_id_t    dstm;
        word_t      vala;
        word_t      valb;
    } de_bundle_t;

    // A bubble looks like a nop that touches no registers.
    function automatic de_bundle_t bubble();
        de_bundle_t b;
        b       = '0;
        b.icode = ICodeNop;
        b.srca  = RNONE;
        b.srcb  = RNONE;
        b.dste  = RNONE;
        b.dstm  = RNONE;
        return b;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two write ports (M beats E), two bypassed reads, debug read.
module y86_regfile
    import y86_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          w_dst_e,
    input  logic [DATA_W-1:0]   w_val_e,
    input  logic [3:0]          w_dst_m,
    input  logic [DATA_W-1:0]   w_val_m,
    input  logic [3:0]          rd_addr_a,
    output logic [DATA_W-1:0]   rd_data_a,
    input  logic [3:0]          rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic [3:0]          dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    word_t regs_q [NREGS];

    // The M write is issued last so it takes effect when both ports hit the same ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            if (w_dst_e != RNONE) regs_q[w_dst_e] <= w_val_e;
            if (w_dst_m != RNONE) regs_q[w_dst_m] <= w_val_m;
        end
    end

    function automatic word_t read_port(reg_id_t addr, word_t stored,
                                        reg_id_t de, word_t ve,
                                        reg_id_t dm, word_t vm);
        if (addr == RNONE)   return '0;
        else if (addr == dm) return vm;
        else if (addr == de) return ve;
        else                 return stored;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a, regs_q[rd_addr_a], w_dst_e, w_val_e, w_dst_m, w_val_m);
        rd_data_b = read_port(rd_addr_b, regs_q[rd_addr_b], w_dst_e, w_val_e, w_dst_m, w_val_m);
        dbg_data  = (dbg_addr == RNONE) ? '0 : regs_q[dbg_addr];
    end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode/writeback stage: register ID selection, register-file read and the
// decode->execute pipeline register.
module decode_regfile
    import y86_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [3:0]          iCode,
    input  logic [3:0]          ifun,
    input  logic [3:0]          rA,
    input  logic [3:0]          rB,
    input  logic [DATA_W-1:0]   ValC,
    input  logic [DATA_W-1:0]   ValP,
    input  logic                stall,
    input  logic                flush,
    input  logic [3:0]          w_dstE,
    input  logic [DATA_W-1:0]   w_valE,
    input  logic [3:0]          w_dstM,
    input  logic [DATA_W-1:0]   w_valM,
    output logic                out_valid,
    output logic [3:0]          d_iCode,
    output logic [3:0]          d_ifun,
    output logic [DATA_W-1:0]   d_ValC,
    output logic [DATA_W-1:0]   d_ValP,
    output logic [3:0]          srcA,
    output logic [3:0]          srcB,
    output logic [3:0]          dstE,
    output logic [3:0]          dstM,
    output logic [DATA_W-1:0]   valA,
    output logic [DATA_W-1:0]   valB,
    input  logic [3:0]          dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    reg_id_t    src_a, src_b, dst_e, dst_m;
    word_t      rd_a, rd_b;
    de_bundle_t pipe_d, pipe_q;

    // Unknown iCodes fall to the default arm and touch no registers.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (iCode)
            ICodeCmov:   begin src_a = rA;     dst_e = rB;                                  end
            ICodeIrmovq: begin dst_e = rB;                                                  end
            ICodeRmmovq: begin src_a = rA;     src_b = rB;                                  end
            ICodeMrmovq: begin src_b = rB;     dst_m = rA;                                  end
            ICodeOpq:    begin src_a = rA;     src_b = rB;     dst_e = rB;                  end
            ICodeCall:   begin src_b = RSP_ID; dst_e = RSP_ID;                              end
            ICodeRet:    begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID;              end
            ICodePushq:  begin src_a = rA;     src_b = RSP_ID; dst_e = RSP_ID;              end
            ICodePopq:   begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = rA;  end
            default:     ;
        endcase
    end

    y86_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .w_dst_e   (w_dstE),
        .w_val_e   (w_valE),
        .w_dst_m   (w_dstM),
        .w_val_m   (w_valM),
        .rd_addr_a (src_a),
        .rd_data_a (rd_a),
        .rd_addr_b (src_b),
        .rd_data_b (rd_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            pipe_d = bubble();
        end else if (!stall) begin
            if (in_valid) begin
                pipe_d.valid = 1'b1;
                pipe_d.icode = iCode;
                pipe_d.ifun  = ifun;
                pipe_d.valc  = ValC;
                pipe_d.valp  = ValP;
                pipe_d.srca  = src_a;
                pipe_d.srcb  = src_b;
                pipe_d.dste  = dst_e;
                pipe_d.dstm  = dst_m;
                pipe_d.vala  = rd_a;
                pipe_d.valb  = rd_b;
            end else begin
                pipe_d = bubble();
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pipe_q <= bubble();
        else     pipe_q <= pipe_d;
    end

    assign out_valid = pipe_q.valid;
    assign d_iCode   = pipe_q.icode;
    assign d_ifun    = pipe_q.ifun;
    assign d_ValC    = pipe_q.valc;
    assign d_ValP    = pipe_q.valp;
    assign srcA      = pipe_q.srca;
    assign srcB      = pipe_q.srcb;
    assign dstE      = pipe_q.dste;
    assign dstM      = pipe_q.dstm;
    assign valA      = pipe_q.vala;
    assign valB      = pipe_q.valb;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: vector table plus stall/flush/reset sequences.
module tb_decode_regfile;

    logic        clk, rst, in_valid, stall, flush;
    logic [3:0]  iCode, ifun, rA, rB, w_dstE, w_dstM, dbg_addr;
    logic [63:0] ValC, ValP, w_valE, w_valM, dbg_data;
    logic        out_valid;
    logic [3:0]  d_iCode, d_ifun, srcA, srcB, dstE, dstM;
    logic [63:0] d_ValC, d_ValP, valA, valB;

    int tests = 0;
    int fails = 0;

    decode_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .iCode     (iCode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .ValC      (ValC),
        .ValP      (ValP),
        .stall     (stall),
        .flush     (flush),
        .w_dstE    (w_dstE),
        .w_valE    (w_valE),
        .w_dstM    (w_dstM),
        .w_valM    (w_valM),
        .out_valid (out_valid),
        .d_iCode   (d_iCode),
        .d_ifun    (d_ifun),
        .d_ValC    (d_ValC),
        .d_ValP    (d_ValP),
        .srcA      (srcA),
        .srcB      (srcB),
        .dstE      (dstE),
        .dstM      (dstM),
        .valA      (valA),
        .valB      (valB),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        in_valid;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [3:0]  wde;
        logic [63:0] wve;
        logic [3:0]  wdm;
        logic [63:0] wvm;
        logic        e_valid;
        logic [3:0]  e_icode, e_ifun;
        logic [63:0] e_valc, e_valp;
        logic [3:0]  e_srca, e_srcb, e_dste, e_dstm;
        logic [63:0] e_vala, e_valb;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input logic [3:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg[%0d]", a), dbg_data, exp);
    endtask

    task automatic idle_inputs();
        in_valid = 0; iCode = 4'h1; ifun = 0; rA = 4'hF; rB = 4'hF;
        ValC = 0; ValP = 0; stall = 0; flush = 0;
        w_dstE = 4'hF; w_valE = 0; w_dstM = 4'hF; w_valM = 0;
    endtask

    initial begin
        // in_valid, icode, ifun, rA, rB, ValC, ValP, wdE, wvE, wdM, wvM,
        // exp: valid, icode, ifun, ValC, ValP, srcA, srcB, dstE, dstM, valA, valB
        vecs[0]  = '{1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h0, 4'h3, 64'h1234, 4'hF, 64'h0,
                     1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0};
        vecs[1]  = '{1'b1, 4'h6, 4'h1, 4'h3, 4'h3, 64'h0, 64'h2, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h6, 4'h1, 64'h0, 64'h2, 4'h3, 4'h3, 4'h3, 4'hF,
                     64'h1234, 64'h1234};
        vecs[2]  = '{1'b1, 4'hB, 4'h0, 4'h2, 4'hF, 64'h0, 64'h4, 4'h4, 64'h100, 4'h4, 64'h200,
                     1'b1, 4'hB, 4'h0, 64'h0, 64'h4, 4'h4, 4'h4, 4'h4, 4'h2, 64'h200, 64'h200};
        vecs[3]  = '{1'b1, 4'h3, 4'h0, 4'hF, 4'h5, 64'h55, 64'hE, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h3, 4'h0, 64'h55, 64'hE, 4'hF, 4'hF, 4'h5, 4'hF, 64'h0, 64'h0};
        vecs[4]  = '{1'b1, 4'hC, 4'h0, 4'h1, 4'h1, 64'h9, 64'hA, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'hC, 4'h0, 64'h9, 64'hA, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0};
        vecs[5]  = '{1'b1, 4'h4, 4'h0, 4'h3, 4'h4, 64'h8, 64'h18, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h4, 4'h0, 64'h8, 64'h18, 4'h3, 4'h4, 4'hF, 4'hF,
                     64'h1234, 64'h200};
        vecs[6]  = '{1'b1, 4'h5, 4'h0, 4'h6, 4'h4, 64'h10, 64'h22, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h5, 4'h0, 64'h10, 64'h22, 4'hF, 4'h4, 4'hF, 4'h6, 64'h0, 64'h200};
        vecs[7]  = '{1'b1, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h24, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'hA, 4'h0, 64'h0, 64'h24, 4'h3, 4'h4, 4'h4, 4'hF,
                     64'h1234, 64'h200};
        vecs[8]  = '{1'b1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h25, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h9, 4'h0, 64'h0, 64'h25, 4'h4, 4'h4, 4'h4, 4'hF, 64'h200, 64'h200};
        vecs[9]  = '{1'b1, 4'h2, 4'h3, 4'h3, 4'h7, 64'h0, 64'h27, 4'hF, 64'h0, 4'hF, 64'h0,
                     1'b1, 4'h2, 4'h3, 64'h0, 64'h27, 4'h3, 4'hF, 4'h7, 4'hF, 64'h1234, 64'h0};
        vecs[10] = '{1'b0, 4'h6, 4'h0, 4'h5, 4'h5, 64'h0, 64'h0, 4'h5, 64'hAA, 4'h5, 64'hBB,
                     1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0};
        vecs[11] = '{1'b1, 4'h6, 4'h0, 4'h6, 4'h1, 64'h0, 64'h2A, 4'h6, 64'h66, 4'h1, 64'h11,
                     1'b1, 4'h6, 4'h0, 64'h0, 64'h2A, 4'h6, 4'h1, 4'h1, 4'hF, 64'h66, 64'h11};

        idle_inputs();
        dbg_addr = 0;
        rst = 1;
        tick();
        tick();
        chk("rst out_valid", {63'b0, out_valid}, 0);
        chk("rst d_iCode", d_iCode, 4'h1);
        chk("rst dstE", dstE, 4'hF);
        chk("rst dstM", dstM, 4'hF);
        chk("rst srcA", srcA, 4'hF);
        chk("rst valA", valA, 0);
        rst = 0;
        for (int a = 0; a < 16; a++) dbg_chk(a[3:0], 0);

        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].in_valid; iCode = vecs[i].icode; ifun = vecs[i].ifun;
            rA = vecs[i].ra; rB = vecs[i].rb; ValC = vecs[i].valc; ValP = vecs[i].valp;
            w_dstE = vecs[i].wde; w_valE = vecs[i].wve;
            w_dstM = vecs[i].wdm; w_valM = vecs[i].wvm;
            tick();
            chk($sformatf("v%0d out_valid", i), {63'b0, out_valid}, {63'b0, vecs[i].e_valid});
            chk($sformatf("v%0d d_iCode", i), d_iCode, vecs[i].e_icode);
            chk($sformatf("v%0d d_ifun", i), d_ifun, vecs[i].e_ifun);
            chk($sformatf("v%0d d_ValC", i), d_ValC, vecs[i].e_valc);
            chk($sformatf("v%0d d_ValP", i), d_ValP, vecs[i].e_valp);
            chk($sformatf("v%0d srcA", i), srcA, vecs[i].e_srca);
            chk($sformatf("v%0d srcB", i), srcB, vecs[i].e_srcb);
            chk($sformatf("v%0d dstE", i), dstE, vecs[i].e_dste);
            chk($sformatf("v%0d dstM", i), dstM, vecs[i].e_dstm);
            chk($sformatf("v%0d valA", i), valA, vecs[i].e_vala);
            chk($sformatf("v%0d valB", i), valB, vecs[i].e_valb);
        end
        idle_inputs();
        dbg_chk(4'd3, 64'h1234);
        dbg_chk(4'd4, 64'h200);
        dbg_chk(4'd5, 64'hBB);
        dbg_chk(4'd6, 64'h66);
        dbg_chk(4'd1, 64'h11);
        dbg_chk(4'hF, 64'h0);

        // Stall: call held for three cycles while a write to reg 7 lands.
        in_valid = 1; iCode = 4'h8; ifun = 0; rA = 4'hF; rB = 4'hF; ValC = 64'h40; ValP = 64'h9;
        tick();
        chk("call d_iCode", d_iCode, 4'h8);
        chk("call valB", valB, 64'h200);
        for (int k = 0; k < 3; k++) begin
            stall = 1; iCode = 4'h6; rA = 4'h1; rB = 4'h1; ValC = 64'h77; ValP = 64'h99;
            w_dstE = (k == 0) ? 4'd7 : 4'hF; w_valE = 64'h77;
            tick();
            chk($sformatf("stall%0d out_valid", k), {63'b0, out_valid}, 1);
            chk($sformatf("stall%0d d_iCode", k), d_iCode, 4'h8);
            chk($sformatf("stall%0d srcB", k), srcB, 4'h4);
            chk($sformatf("stall%0d dstE", k), dstE, 4'h4);
            chk($sformatf("stall%0d d_ValC", k), d_ValC, 64'h40);
            chk($sformatf("stall%0d d_ValP", k), d_ValP, 64'h9);
        end
        idle_inputs();
        dbg_chk(4'd7, 64'h77);

        // Flush beats stall.
        stall = 1; flush = 1; in_valid = 1; iCode = 4'h3; rA = 4'hF; rB = 4'h2; ValC = 64'h5;
        tick();
        chk("flush out_valid", {63'b0, out_valid}, 0);
        chk("flush d_iCode", d_iCode, 4'h1);
        chk("flush srcA", srcA, 4'hF);
        chk("flush srcB", srcB, 4'hF);
        chk("flush dstE", dstE, 4'hF);
        chk("flush dstM", dstM, 4'hF);
        chk("flush d_ValC", d_ValC, 0);
        idle_inputs();

        // Reset during stall overrides the held bundle and a concurrent write.
        in_valid = 1; iCode = 4'h6; rA = 4'h3; rB = 4'h3; ValC = 64'h31;
        tick();
        chk("pre-rst out_valid", {63'b0, out_valid}, 1);
        chk("pre-rst valA", valA, 64'h1234);
        stall = 1; rst = 1; w_dstE = 4'd3; w_valE = 64'hDEAD;
        tick();
        chk("rst2 out_valid", {63'b0, out_valid}, 0);
        chk("rst2 d_iCode", d_iCode, 4'h1);
        chk("rst2 srcA", srcA, 4'hF);
        chk("rst2 dstE", dstE, 4'hF);
        chk("rst2 valA", valA, 0);
        chk("rst2 d_ValC", d_ValC, 0);
        rst = 0;
        idle_inputs();
        for (int a = 0; a < 16; a++) dbg_chk(a[3:0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
